// File: rtl/store_pack_buffer_pkg.sv
// Shared types and the store formatter for the store pack buffer.
// Entries hold word address, lane-replicated data and byte enables.
package store_pkg;

    localparam int AW = 32;

    localparam logic [5:0] OP_SB = 6'h28;
    localparam logic [5:0] OP_SH = 6'h29;
    localparam logic [5:0] OP_SW = 6'h2b;

    typedef struct packed {
        logic [AW-1:2] addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
    } entry_t;

    typedef struct packed {
        entry_t e;
        logic   bad;
    } fmt_t;

    function automatic fmt_t fmt_store(
        input logic [5:0]    op,
        input logic [AW-1:0] addr,
        input logic [31:0]   data
    );
        fmt_t       r;
        logic [1:0] a;
        a          = addr[1:0];
        r.e.addr   = addr[AW-1:2];
        r.e.wdata  = '0;
        r.e.be     = '0;
        r.bad      = 1'b1;
        unique case (1'b1)
            (op == OP_SB): begin
                r.e.be    = 4'b0001 << a;
                r.e.wdata = {4{data[7:0]}};
                r.bad     = 1'b0;
            end
            (op == OP_SH): begin
                r.e.be    = a[1] ? 4'b1100 : 4'b0011;
                r.e.wdata = {2{data[15:0]}};
                r.bad     = a[0];
            end
            (op == OP_SW): begin
                r.e.be    = 4'b1111;
                r.e.wdata = data;
                r.bad     = (a != 2'b00);
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/store_pack_buffer_if.sv
// Store request, memory drain and snoop signals of the store pack buffer.
// master drives requests and memory acceptance; slave is the buffer.
interface store_pack_buffer_if #(
    parameter int AW    = 32,
    parameter int DEPTH = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [5:0]             in_op;
    logic [AW-1:0]          in_addr;
    logic [31:0]            in_data;
    logic                   mem_valid;
    logic                   mem_ready;
    logic [AW-1:0]          mem_addr;
    logic [31:0]            mem_wdata;
    logic [3:0]             mem_be;
    logic                   err;
    logic [AW-1:0]          snoop_addr;
    logic                   snoop_hit;
    logic [$clog2(DEPTH):0] count;

    modport master (
        output in_valid, in_op, in_addr, in_data,
        output mem_ready, snoop_addr,
        input  in_ready, mem_valid, mem_addr, mem_wdata,
        input  mem_be, err, snoop_hit, count
    );

    modport slave (
        input  in_valid, in_op, in_addr, in_data,
        input  mem_ready, snoop_addr,
        output in_ready, mem_valid, mem_addr, mem_wdata,
        output mem_be, err, snoop_hit, count
    );
endinterface

// File: rtl/store_fmt.sv
// Combinational store formatter: byte lanes, enables and drop flag.
module store_fmt
    import store_pkg::*;
(
    input  logic [5:0]    op,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   data,
    output entry_t        e,
    output logic          bad
);
    fmt_t r;

    assign r   = fmt_store(op, addr, data);
    assign e   = r.e;
    assign bad = r.bad;
endmodule

// File: rtl/store_pack_buffer.sv
// Store queue between MEM stage and data memory, with a word snoop
// port so dependent loads can be held while a store is pending.
module store_pack_buffer
    import store_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    store_pack_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    entry_t        q [DEPTH];
    entry_t        fe;
    entry_t        hd;
    logic          bad;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] idx;
    logic [PW:0]   cnt;
    logic          errq;
    logic          full;
    logic          pop;
    logic          acc;
    logic          push;
    logic          hit;
    logic          unused_snoop;

    store_fmt u_fmt (
        .op   (bus.in_op),
        .addr (bus.in_addr),
        .data (bus.in_data),
        .e    (fe),
        .bad  (bad)
    );

    assign full = (cnt == (PW+1)'(DEPTH));
    assign pop  = (cnt != '0) && bus.mem_ready;
    assign acc  = bus.in_valid && bus.in_ready;
    assign push = acc && !bad;

    // Pop-before-push lets a full queue take a request while draining.
    assign bus.in_ready = !full || pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            errq <= 1'b0;
        end else begin
            errq <= acc && bad;
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    // Storage needs no reset: outputs and snoop are gated by cnt.
    always_ff @(posedge clk) begin
        if (push) q[tail] <= fe;
    end

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((PW+1)'(i) < cnt &&
                q[idx].addr == bus.snoop_addr[AW-1:2])
                hit = 1'b1;
        end
    end

    assign hd            = (cnt != '0) ? q[head] : '0;
    assign bus.mem_valid = (cnt != '0);
    assign bus.mem_addr  = {hd.addr, 2'b00};
    assign bus.mem_wdata = hd.wdata;
    assign bus.mem_be    = hd.be;
    assign bus.err       = errq;
    assign bus.snoop_hit = hit;
    assign bus.count     = cnt;
    assign unused_snoop  = ^bus.snoop_addr[1:0];
endmodule

// File: tb/tb_store_pack_buffer.sv
// Self-checking bench for store_pack_buffer: vector table, corner
// sequences and a queue scoreboard watching every cycle.
module tb_store_pack_buffer;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic        bad;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mdl_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        bad;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;
    mdl_t sb[$];
    logic err_pend = 1'b0;
    vec_t vecs[10];

    always #5 clk = ~clk;

    store_pack_buffer_if #(.AW(AW), .DEPTH(DEPTH)) sif ();

    store_pack_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic mdl_t fmt_model(input logic [5:0] op,
                                       input logic [31:0] addr,
                                       input logic [31:0] data);
        mdl_t m;
        logic [1:0] a;
        a       = addr[1:0];
        m.addr  = {addr[31:2], 2'b00};
        m.bad   = 1'b1;
        m.be    = 4'h0;
        m.wdata = 32'h0;
        case (op)
            6'h28: begin
                m.bad   = 1'b0;
                m.be    = (a == 2'd0) ? 4'h1 : (a == 2'd1) ? 4'h2 :
                          (a == 2'd2) ? 4'h4 : 4'h8;
                m.wdata = {24'h0, data[7:0]} * 32'h01010101;
            end
            6'h29: begin
                m.bad   = a[0];
                m.be    = a[1] ? 4'hC : 4'h3;
                m.wdata = {data[15:0], data[15:0]};
            end
            6'h2b: begin
                m.bad   = (a != 2'd0);
                m.be    = 4'hF;
                m.wdata = data;
            end
            default: m.bad = 1'b1;
        endcase
        return m;
    endfunction

    // Scoreboard: compare state, then apply this cycle's pop/push.
    always @(negedge clk) begin
        mdl_t m;
        logic rdy;
        logic hit;
        if (rst) begin
            sb.delete();
            err_pend = 1'b0;
        end else begin
            rdy = (sb.size() < DEPTH) ||
                  (sb.size() != 0 && sif.mem_ready);
            chk("count", 32'(sif.count), 32'(sb.size()));
            chk("mem_valid", 32'(sif.mem_valid), 32'(sb.size() != 0));
            chk("in_ready", 32'(sif.in_ready), 32'(rdy));
            chk("err", 32'(sif.err), 32'(err_pend));
            hit = 1'b0;
            foreach (sb[i])
                if (sb[i].addr[31:2] == sif.snoop_addr[31:2]) hit = 1'b1;
            chk("snoop_hit", 32'(sif.snoop_hit), 32'(hit));
            if (sb.size() != 0) begin
                chk("head_addr", sif.mem_addr, sb[0].addr);
                chk("head_wdata", sif.mem_wdata, sb[0].wdata);
                chk("head_be", 32'(sif.mem_be), 32'(sb[0].be));
            end else begin
                chk("idle_addr", sif.mem_addr, 32'h0);
                chk("idle_wdata", sif.mem_wdata, 32'h0);
                chk("idle_be", 32'(sif.mem_be), 32'h0);
            end
            m = fmt_model(sif.in_op, sif.in_addr, sif.in_data);
            err_pend = sif.in_valid && rdy && m.bad;
            if (sb.size() != 0 && sif.mem_ready) void'(sb.pop_front());
            if (sif.in_valid && rdy && !m.bad) sb.push_back(m);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] data);
        sif.in_valid = 1'b1;
        sif.in_op    = op;
        sif.in_addr  = addr;
        sif.in_data  = data;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [5:0] ops[5];
        ops[0] = 6'h28; ops[1] = 6'h29; ops[2] = 6'h2b;
        ops[3] = 6'h23; ops[4] = 6'h00;

        vecs[0] = '{6'h28, 32'h1003, 32'h000000A5, 4'h8, 32'hA5A5A5A5, 1'b0};
        vecs[1] = '{6'h29, 32'h2002, 32'h1234BEEF, 4'hC, 32'hBEEFBEEF, 1'b0};
        vecs[2] = '{6'h2b, 32'h2001, 32'h11111111, 4'h0, 32'h0, 1'b1};
        vecs[3] = '{6'h23, 32'h1000, 32'h22222222, 4'h0, 32'h0, 1'b1};
        vecs[4] = '{6'h28, 32'h1000, 32'h12345678, 4'h1, 32'h78787878, 1'b0};
        vecs[5] = '{6'h28, 32'h1001, 32'h000000FF, 4'h2, 32'hFFFFFFFF, 1'b0};
        vecs[6] = '{6'h28, 32'h1002, 32'h0000003C, 4'h4, 32'h3C3C3C3C, 1'b0};
        vecs[7] = '{6'h29, 32'h1000, 32'hCAFE0011, 4'h3, 32'h00110011, 1'b0};
        vecs[8] = '{6'h29, 32'h1003, 32'h33333333, 4'h0, 32'h0, 1'b1};
        vecs[9] = '{6'h2b, 32'h2004, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0};

        rst            = 1'b1;
        sif.in_valid   = 1'b0;
        sif.in_op      = 6'h0;
        sif.in_addr    = 32'h0;
        sif.in_data    = 32'h0;
        sif.mem_ready  = 1'b0;
        sif.snoop_addr = 32'h0;
        repeat (2) step();
        chk("rst_count", 32'(sif.count), 32'h0);
        chk("rst_mem_valid", 32'(sif.mem_valid), 32'h0);
        chk("rst_err", 32'(sif.err), 32'h0);
        chk("rst_snoop", 32'(sif.snoop_hit), 32'h0);
        chk("rst_mem_addr", sif.mem_addr, 32'h0);
        chk("rst_mem_be", 32'(sif.mem_be), 32'h0);
        rst = 1'b0;
        step();

        sif.mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].op, vecs[i].addr, vecs[i].data);
            step();
            sif.in_valid = 1'b0;
            if (vecs[i].bad) begin
                chk("vec_err", 32'(sif.err), 32'h1);
                chk("vec_drop_count", 32'(sif.count), 32'h0);
            end else begin
                chk("vec_valid", 32'(sif.mem_valid), 32'h1);
                chk("vec_addr", sif.mem_addr,
                    {vecs[i].addr[31:2], 2'b00});
                chk("vec_be", 32'(sif.mem_be), 32'(vecs[i].be));
                chk("vec_wdata", sif.mem_wdata, vecs[i].wdata);
                chk("vec_count", 32'(sif.count), 32'h1);
            end
            step();
        end

        // sh kept, misaligned sw dropped behind it
        sif.mem_ready = 1'b0;
        drive(6'h29, 32'h2002, 32'h1234BEEF);
        step();
        drive(6'h2b, 32'h2001, 32'h55555555);
        step();
        sif.in_valid = 1'b0;
        chk("drop_err", 32'(sif.err), 32'h1);
        chk("drop_count", 32'(sif.count), 32'h1);
        chk("drop_head_be", 32'(sif.mem_be), 32'hC);
        step();
        chk("drop_err_once", 32'(sif.err), 32'h0);
        chk("drop_count2", 32'(sif.count), 32'h1);
        sif.mem_ready = 1'b1;
        step();
        chk("drop_drained", 32'(sif.count), 32'h0);

        // back-to-back drops
        drive(6'h23, 32'h3000, 32'h0);
        step();
        chk("b2b_err1", 32'(sif.err), 32'h1);
        drive(6'h2b, 32'h3002, 32'h0);
        step();
        sif.in_valid = 1'b0;
        chk("b2b_err2", 32'(sif.err), 32'h1);
        chk("b2b_count", 32'(sif.count), 32'h0);
        step();
        chk("b2b_err3", 32'(sif.err), 32'h0);

        // fill, hold, then stream while full
        sif.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(6'h2b, 32'h3000 + 32'(4 * i), 32'hA0 + 32'(i));
            step();
        end
        sif.in_valid = 1'b0;
        chk("full_count", 32'(sif.count), 32'h4);
        chk("full_in_ready", 32'(sif.in_ready), 32'h0);
        repeat (10) step();
        chk("hold_addr", sif.mem_addr, 32'h3000);
        chk("hold_wdata", sif.mem_wdata, 32'hA0);
        chk("hold_be", 32'(sif.mem_be), 32'hF);
        drive(6'h2b, 32'h3100, 32'hB0);
        sif.mem_ready = 1'b1;
        #1;
        chk("stream_ready0", 32'(sif.in_ready), 32'h1);
        for (int k = 1; k <= 6; k++) begin
            step();
            drive(6'h2b, 32'h3100 + 32'(4 * k), 32'hB0 + 32'(k));
            #1;
            chk("stream_count", 32'(sif.count), 32'h4);
            chk("stream_ready", 32'(sif.in_ready), 32'h1);
        end
        sif.in_valid = 1'b0;
        for (int k = 0; k < 10 && sif.count != 0; k++) step();
        chk("stream_drained", 32'(sif.count), 32'h0);

        // snoop against queued words
        sif.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(6'h2b, 32'h100 + 32'(4 * i), 32'hC0 + 32'(i));
            step();
        end
        sif.in_valid   = 1'b0;
        sif.snoop_addr = 32'h106;
        #1;
        chk("snoop_106", 32'(sif.snoop_hit), 32'h1);
        sif.snoop_addr = 32'h10C;
        #1;
        chk("snoop_10c", 32'(sif.snoop_hit), 32'h0);
        sif.mem_ready = 1'b1;
        repeat (2) step();
        sif.mem_ready  = 1'b0;
        sif.snoop_addr = 32'h106;
        #1;
        chk("snoop_106_gone", 32'(sif.snoop_hit), 32'h0);
        sif.snoop_addr = 32'h108;
        #1;
        chk("snoop_108", 32'(sif.snoop_hit), 32'h1);
        sif.mem_ready = 1'b1;
        step();
        sif.mem_ready = 1'b0;

        // asynchronous reset with entries queued
        for (int i = 0; i < 3; i++) begin
            drive(6'h28, 32'h200 + 32'(i), 32'h10 + 32'(i));
            step();
        end
        sif.in_valid = 1'b0;
        chk("pre_rst_valid", 32'(sif.mem_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(sif.mem_valid), 32'h0);
        chk("arst_count", 32'(sif.count), 32'h0);
        step();
        rst = 1'b0;
        drive(6'h28, 32'h55, 32'h7E);
        step();
        sif.in_valid = 1'b0;
        chk("post_rst_count", 32'(sif.count), 32'h1);
        chk("post_rst_addr", sif.mem_addr, 32'h54);
        chk("post_rst_be", 32'(sif.mem_be), 32'h2);
        chk("post_rst_wdata", sif.mem_wdata, 32'h7E7E7E7E);
        sif.mem_ready = 1'b1;
        step();

        // random traffic, checked by the scoreboard
        for (int n = 0; n < 150; n++) begin
            sif.in_valid   = ($urandom_range(0, 3) != 0);
            sif.in_op      = ops[$urandom_range(0, 4)];
            sif.in_addr    = 32'h400 + 32'($urandom_range(0, 31));
            sif.in_data    = $urandom;
            sif.mem_ready  = ($urandom_range(0, 2) != 0);
            sif.snoop_addr = 32'h400 + 32'($urandom_range(0, 31));
            step();
        end
        sif.in_valid  = 1'b0;
        sif.mem_ready = 1'b1;
        repeat (8) step();
        chk("final_count", 32'(sif.count), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/store_pack_buffer.md
# store_pack_buffer

Store-side counterpart of the decode-stage immediate extender: takes MIPS store requests (sb/sh/sw) from the MEM stage, truncates and replicates register data into byte lanes with a 4-bit byte-enable, and queues them in a small FIFO. The queue drains to data memory over a valid/ready handshake. A word-address snoop port flags a pending store to the same word, so the hazard unit can stall dependent loads.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- AW, 32, address width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  store request present
- in_ready  out  1  request accepted this cycle when in_valid && in_ready
- in_op  in  6  MIPS opcode: 6'h28 sb, 6'h29 sh, 6'h2b sw
- in_addr  in  AW  byte address
- in_data  in  32  rt register value
- mem_valid  out  1  head entry presented
- mem_ready  in  1  memory accepts head
- mem_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
- mem_wdata  out  32  lane-replicated data
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- err  out  1  one-cycle pulse: misaligned or unsupported op dropped
- snoop_addr  in  AW  load byte address
- snoop_hit  out  1  combinational: any valid entry matches snoop_addr[AW-1:2]
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Formatting, with a = in_addr[1:0]:
  - sb: be = 4'b0001<<a; wdata = {4{in_data[7:0]}}.
  - sh: be = a[1] ? 4'b1100 : 4'b0011; wdata = {2{in_data[15:0]}}; misaligned if a[0].
  - sw: be = 4'b1111; wdata = in_data; misaligned if a != 0.
  - Any other opcode is unsupported.
- Accept: in_ready = (count < DEPTH) || (mem_valid && mem_ready). Pop-before-push makes room when full.
- Misaligned or unsupported request that is accepted: nothing is enqueued and err = 1 on the following cycle. The request is still consumed, so in_ready is unaffected.
- FIFO: head/tail pointers, each $clog2(DEPTH) bits, wrap modulo DEPTH. mem_valid = (count != 0). The head pops on mem_valid && mem_ready.
- Simultaneous push and pop: count unchanged. Both pointers advance.
- Push and pop on a full FIFO: allowed, count stays DEPTH.
- snoop_hit compares against every valid entry, including an entry popping this cycle. It ignores the entry being pushed this cycle.

## Timing
- Reset values: head = tail = 0, count = 0, mem_valid = 0, err = 0, snoop_hit = 0. mem_addr, mem_wdata and mem_be are 0 when empty.
- Latency: a push at edge N gives mem_valid = 1 after edge N. There is no combinational in→mem path.
- Stability: mem_addr, mem_wdata and mem_be hold while mem_valid && !mem_ready.
- err is registered, high exactly one cycle per dropped request. Back-to-back drops give consecutive err cycles.
- Reset mid-operation: all queued stores are discarded immediately (asynchronous), and mem_valid drops without waiting for a clock.
- in_ready depends combinationally on mem_ready. Memory must not derive mem_ready from in_valid.

## Structure
- Package store_pkg holds:
  - opcode constants OP_SB, OP_SH, OP_SW
  - the entry struct {addr[AW-1:2], wdata, be}
  - function fmt_store(op, addr, data) returning {entry, bad}
- Sub-module store_fmt holds the combinational formatter, instantiated once on the input side.
- FIFO, pointers, snoop comparators and err register live in the top.

## Test plan
- sb, addr 0x1003, data 0x000000A5 -> after one cycle: mem_addr 0x1000, be 4'b1000, wdata 0xA5A5A5A5, count 1.
- sh at 0x2002 with data 0x1234BEEF, then sw at 0x2001 -> first: be 4'b1100, wdata 0xBEEFBEEF. Second: dropped, err high exactly one cycle, count stays 1.
- Push 4 sw with mem_ready = 0 -> count 4, in_ready 0, head fields stable for 10 cycles. Then mem_ready = 1 with in_valid held -> in_ready 1, count stays 4 while streaming.
- 3 stores queued at words 0x100, 0x104, 0x108; snoop_addr 0x106 -> snoop_hit 1. snoop_addr 0x10C -> snoop_hit 0. After 0x104 drains -> 0x106 gives 0.
- Assert rst asynchronously with 3 entries queued and mem_valid high -> mem_valid and count 0 before the next edge. The first push after release appears at entry 0.
- Opcode 6'h23 (lw) presented -> consumed, err pulse, nothing enqueued.
